// File: rtl/tdm_pkg.sv
// tdm_pkg: shared frame-sync types and sizes for the tdm_mux4 / tdm_demux4 pair.
`default_nettype none

package tdm_pkg;
    localparam int NSLOT  = 4;
    localparam int SLOT_W = 2;
    localparam int GCNT_W = 3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } tdm_state_e;

    typedef logic [SLOT_W-1:0] slot_t;
endpackage

`default_nettype wire

// File: rtl/tdm_sync_fsm.sv
// tdm_sync_fsm: frame-sync tracker (state, good-sync counter, slot index) for the 4-slot TDM receiver.
`default_nettype none

module tdm_sync_fsm
    import tdm_pkg::*;
#(
    parameter int LOCK_CNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic       fsync_i,
    output tdm_state_e state_o,
    output slot_t      slot_o,
    output logic       restart_o,
    output logic       wr_en_o,
    output logic       discard_o,
    output logic       frame_done_o,
    output logic       sync_err_o
);
    localparam logic [GCNT_W-1:0] LOCK_CNT_C = GCNT_W'(LOCK_CNT);

    tdm_state_e        state_q, state_d;
    slot_t             slot_q, slot_d;
    logic [GCNT_W-1:0] cnt_q, cnt_d;
    logic              emit_q, emit_d;
    logic [GCNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + GCNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= '0;
            cnt_q   <= '0;
            emit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            emit_q  <= emit_d;
        end
    end

    // emit_q marks a frame whose slot 0 was accepted while already LOCKED;
    // the frame started by the lock-qualifying sync is never output.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        cnt_d        = cnt_q;
        emit_d       = emit_q;
        restart_o    = 1'b0;
        wr_en_o      = 1'b0;
        discard_o    = 1'b0;
        frame_done_o = 1'b0;
        sync_err_o   = 1'b0;
        if (valid_i) begin
            case (state_q)
                HUNT: begin
                    if (fsync_i) begin
                        restart_o = 1'b1;
                        slot_d    = slot_t'(1);
                        cnt_d     = GCNT_W'(1);
                        emit_d    = 1'b0;
                        state_d   = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (fsync_i) begin
                        restart_o = 1'b1;
                        slot_d    = slot_t'(1);
                        emit_d    = 1'b0;
                        if (slot_q == '0) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= LOCK_CNT_C) state_d = LOCKED;
                        end else begin
                            cnt_d = GCNT_W'(1);
                        end
                    end else if (slot_q == '0) begin
                        discard_o = 1'b1;
                        state_d   = HUNT;
                        slot_d    = '0;
                        cnt_d     = '0;
                    end else begin
                        wr_en_o = 1'b1;
                        slot_d  = slot_q + slot_t'(1);
                    end
                end
                LOCKED: begin
                    if (fsync_i) begin
                        sync_err_o = (slot_q != '0);
                        restart_o  = 1'b1;
                        slot_d     = slot_t'(1);
                        emit_d     = 1'b1;
                    end else if (slot_q == '0) begin
                        sync_err_o = 1'b1;
                        discard_o  = 1'b1;
                        state_d    = HUNT;
                        slot_d     = '0;
                        cnt_d      = '0;
                        emit_d     = 1'b0;
                    end else begin
                        wr_en_o      = 1'b1;
                        slot_d       = slot_q + slot_t'(1);
                        frame_done_o = (slot_q == slot_t'(NSLOT - 1)) && emit_q;
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                    cnt_d   = '0;
                    emit_d  = 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign slot_o  = slot_q;
endmodule

`default_nettype wire

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot serial TDM receiver; frame-sync tracking plus slot capture into a parallel frame.
`default_nettype none

module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int LOCK_CNT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_valid,
    input  logic              din,
    input  logic              fsync,
    output logic [NSLOT-1:0]  dout,
    output logic              dout_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
);
    // Assert asynchronously, release on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    tdm_state_e       state_w;
    slot_t            slot_w;
    logic             restart_w, wr_en_w, discard_w, frame_done_w, sync_err_w;
    logic [NSLOT-1:0] frame_q, frame_d;
    logic [NSLOT-1:0] dout_q, dout_d;
    logic             dout_valid_q, sync_err_q;

    tdm_sync_fsm #(
        .LOCK_CNT (LOCK_CNT)
    ) u_sync (
        .clk          (clk),
        .rst_n        (rst_int_n),
        .valid_i      (din_valid),
        .fsync_i      (fsync),
        .state_o      (state_w),
        .slot_o       (slot_w),
        .restart_o    (restart_w),
        .wr_en_o      (wr_en_w),
        .discard_o    (discard_w),
        .frame_done_o (frame_done_w),
        .sync_err_o   (sync_err_w)
    );

    always_comb begin
        frame_d = frame_q;
        dout_d  = dout_q;
        if (discard_w) begin
            frame_d = '0;
        end else if (restart_w) begin
            frame_d = {{(NSLOT-1){1'b0}}, din};
        end else if (wr_en_w) begin
            frame_d[slot_w] = din;
        end
        if (frame_done_w) dout_d = {din, frame_q[NSLOT-2:0]};
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            frame_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            frame_q      <= frame_d;
            dout_q       <= dout_d;
            dout_valid_q <= frame_done_w;
            sync_err_q   <= sync_err_w;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_w;
    assign locked     = (state_w == LOCKED);
    assign sync_err   = sync_err_q;
endmodule

`default_nettype wire

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed scenarios plus randomized streams checked against a frame-level reference model.
`default_nettype none

module tb_tdm_demux4;
    localparam int LOCK_CNT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic       fsync = 1'b0;
    logic [3:0] dout;
    logic       dout_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;

    int n_checks = 0;
    int n_fail   = 0;
    int dv_cnt   = 0;
    int se_cnt   = 0;

    // Reference model: 0 = hunting, 1 = verifying, 2 = locked
    int         m_mode;
    int         m_pos;
    int         m_good;
    bit         m_emit;
    bit         m_bits [4];
    logic [3:0] m_dout;
    bit         m_dv;
    bit         m_se;

    tdm_demux4 #(.LOCK_CNT(LOCK_CNT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din        (din),
        .fsync      (fsync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_emit = 0;
        m_dout = 4'b0000; m_dv = 0; m_se = 0;
        for (int k = 0; k < 4; k++) m_bits[k] = 0;
    endtask

    task automatic model_new_frame(input bit d);
        for (int k = 0; k < 4; k++) m_bits[k] = 0;
        m_bits[0] = d;
        m_pos = 1;
    endtask

    task automatic model_lose_sync();
        m_mode = 0; m_pos = 0; m_good = 0; m_emit = 0;
    endtask

    task automatic model_add_bit(input bit d);
        m_bits[m_pos] = d;
        if (m_pos == 3) begin
            if (m_mode == 2 && m_emit) begin
                m_dout = {d, m_bits[2], m_bits[1], m_bits[0]};
                m_dv = 1;
            end
            m_pos = 0;
        end else begin
            m_pos = m_pos + 1;
        end
    endtask

    task automatic model_step(input bit v, input bit d, input bit fs);
        m_dv = 0;
        m_se = 0;
        if (v) begin
            if (m_mode == 0) begin
                if (fs) begin
                    model_new_frame(d);
                    m_good = 1; m_emit = 0;
                    m_mode = (LOCK_CNT == 1) ? 2 : 1;
                end
            end else if (m_mode == 1) begin
                if (fs) begin
                    m_good = (m_pos == 0) ? m_good + 1 : 1;
                    model_new_frame(d);
                    m_emit = 0;
                    if (m_good >= LOCK_CNT) m_mode = 2;
                end else if (m_pos == 0) begin
                    model_lose_sync();
                end else begin
                    model_add_bit(d);
                end
            end else begin
                if (fs) begin
                    m_se = (m_pos != 0);
                    model_new_frame(d);
                    m_emit = 1;
                end else if (m_pos == 0) begin
                    m_se = 1;
                    model_lose_sync();
                end else begin
                    model_add_bit(d);
                end
            end
        end
    endtask

    task automatic step(input bit v, input bit d, input bit fs);
        din_valid = v; din = d; fsync = fs;
        @(posedge clk);
        #1;
        model_step(v, d, fs);
        if (dout_valid === 1'b1) dv_cnt++;
        if (sync_err === 1'b1) se_cnt++;
    endtask

    task automatic send_frame(input logic [3:0] b);
        for (int k = 0; k < 4; k++) step(1'b1, b[k], k == 0);
    endtask

    task automatic reset_low();
        rst_n = 1'b0; din_valid = 1'b0; din = 1'b0; fsync = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_low();
        n_checks++; if (dout !== 4'b0000) begin n_fail++; $display("FAIL rst_dout: got %b want 0000", dout); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dout_valid: got %b want 0", dout_valid); end
        n_checks++; if (slot !== 2'd0) begin n_fail++; $display("FAIL rst_slot: got %0d want 0", slot); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b want 0", locked); end
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL rst_sync_err: got %b want 0", sync_err); end
        reset_release();
        step(1'b1, 1'b1, 1'b0);
        n_checks++; if (slot !== 2'd0) begin n_fail++; $display("FAIL hunt_discard_slot: got %0d want 0", slot); end
    endtask

    task automatic test_lock_sequence();
        int dv0;
        dv0 = dv_cnt;
        send_frame(4'b0101);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_after_f1: got %b want 0", locked); end
        step(1'b1, 1'b0, 1'b1);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_at_sync2: got %b want 1", locked); end
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
        n_checks++; if (dv_cnt - dv0 != 0) begin n_fail++; $display("FAIL lock_f2_no_out: got %0d pulses want 0", dv_cnt - dv0); end
        send_frame(4'b1111);
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL lock_f3_valid: got %b want 1", dout_valid); end
        n_checks++; if (dout !== 4'b1111) begin n_fail++; $display("FAIL lock_f3_dout: got %b want 1111", dout); end
        n_checks++; if (dv_cnt - dv0 != 1) begin n_fail++; $display("FAIL lock_pulse_count: got %0d want 1", dv_cnt - dv0); end
    endtask

    task automatic test_valid_gaps();
        int dv0;
        dv0 = dv_cnt;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        n_checks++; if (slot !== 2'd1) begin n_fail++; $display("FAIL gap_slot_frozen: got %0d want 1", slot); end
        step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid: got %b want 0", dout_valid); end
        step(1'b1, 1'b1, 1'b0);
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b want 1", dout_valid); end
        n_checks++; if (dout !== 4'b1101) begin n_fail++; $display("FAIL gap_dout: got %b want 1101", dout); end
        step(1'b0, 1'b0, 1'b0);
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL gap_pulse_width: got %b want 0", dout_valid); end
        n_checks++; if (dv_cnt - dv0 != 1) begin n_fail++; $display("FAIL gap_pulse_count: got %0d want 1", dv_cnt - dv0); end
    endtask

    task automatic test_misplaced_sync();
        int dv0;
        dv0 = dv_cnt;
        step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL mis_sync_err: got %b want 1", sync_err); end
        n_checks++; if (slot !== 2'd1) begin n_fail++; $display("FAIL mis_slot: got %0d want 1", slot); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL mis_locked: got %b want 1", locked); end
        step(1'b1, 1'b1, 1'b0);
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL mis_err_width: got %b want 0", sync_err); end
        step(1'b1, 1'b1, 1'b0);
        n_checks++; if (dv_cnt - dv0 != 0) begin n_fail++; $display("FAIL mis_broken_out: got %0d pulses want 0", dv_cnt - dv0); end
        step(1'b1, 1'b1, 1'b0);
        n_checks++; if (dout_valid !== 1'b1 || dout !== 4'b1110) begin n_fail++; $display("FAIL mis_resync_frame: got v=%b d=%b want v=1 d=1110", dout_valid, dout); end
    endtask

    task automatic test_missing_sync();
        step(1'b1, 1'b1, 1'b0);
        n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL miss_sync_err: got %b want 1", sync_err); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL miss_locked: got %b want 0", locked); end
        n_checks++; if (slot !== 2'd0) begin n_fail++; $display("FAIL miss_slot: got %0d want 0", slot); end
        n_checks++; if (dout !== 4'b1110) begin n_fail++; $display("FAIL miss_dout_held: got %b want 1110", dout); end
        step(1'b1, 1'b0, 1'b0);
        n_checks++; if (sync_err !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL miss_after: got err=%b lock=%b want 0 0", sync_err, locked); end
    endtask

    task automatic test_reset_midframe();
        int dv0;
        send_frame(4'b0011); send_frame(4'b1000);
        step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b0);
        n_checks++; if (slot !== 2'd2 || locked !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got slot=%0d lock=%b want 2 1", slot, locked); end
        reset_low();
        n_checks++; if (dout !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_dout: got %b want 0000", dout); end
        n_checks++; if (slot !== 2'd0 || locked !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got slot=%0d lock=%b want 0 0", slot, locked); end
        n_checks++; if (dout_valid !== 1'b0 || sync_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pulses: got v=%b e=%b want 0 0", dout_valid, sync_err); end
        reset_release();
        dv0 = dv_cnt;
        send_frame(4'b0110); send_frame(4'b0101);
        n_checks++; if (dv_cnt - dv0 != 0 || locked !== 1'b1) begin n_fail++; $display("FAIL mid_requal: got pulses=%0d lock=%b want 0 1", dv_cnt - dv0, locked); end
        send_frame(4'b1001);
        n_checks++; if (dout_valid !== 1'b1 || dout !== 4'b1001) begin n_fail++; $display("FAIL mid_first_out: got v=%b d=%b want 1 1001", dout_valid, dout); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] frames [100];
        int n_out, se0;
        reset_low();
        reset_release();
        se0 = se_cnt;
        n_out = 0;
        for (int i = 0; i < 100; i++) frames[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0)
                    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                step(1'b1, frames[i][k], k == 0);
                if (dout_valid === 1'b1) begin
                    n_checks++;
                    if (n_out + 2 > 99 || dout !== frames[n_out + 2]) begin
                        n_fail++;
                        $display("FAIL b2b_frame %0d: got %b want %b", n_out + 2, dout, (n_out + 2 <= 99) ? frames[n_out + 2] : 4'bxxxx);
                    end
                    n_out++;
                end
            end
        end
        n_checks++; if (n_out != 98) begin n_fail++; $display("FAIL b2b_count: got %0d frames want 98", n_out); end
        n_checks++; if (se_cnt - se0 != 0) begin n_fail++; $display("FAIL b2b_sync_err: got %0d pulses want 0", se_cnt - se0); end
    endtask

    task automatic test_random_model();
        int tx_pos;
        bit v, d, fs;
        reset_low();
        reset_release();
        tx_pos = 0;
        for (int c = 0; c < 800; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            fs = v ? ((tx_pos == 0) ^ ($urandom_range(0, 24) == 0)) : 1'($urandom_range(0, 1));
            step(v, d, fs);
            if (v) tx_pos = (tx_pos + 1) % 4;
            if ($urandom_range(0, 149) == 0) tx_pos = $urandom_range(0, 3);
            n_checks++; if (dout !== m_dout) begin n_fail++; $display("FAIL rand_dout c%0d: got %b want %b", c, dout, m_dout); end
            n_checks++; if (dout_valid !== m_dv) begin n_fail++; $display("FAIL rand_dout_valid c%0d: got %b want %b", c, dout_valid, m_dv); end
            n_checks++; if (slot !== 2'(m_pos)) begin n_fail++; $display("FAIL rand_slot c%0d: got %0d want %0d", c, slot, m_pos); end
            n_checks++; if (locked !== (m_mode == 2)) begin n_fail++; $display("FAIL rand_locked c%0d: got %b want %b", c, locked, m_mode == 2); end
            n_checks++; if (sync_err !== m_se) begin n_fail++; $display("FAIL rand_sync_err c%0d: got %b want %b", c, sync_err, m_se); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_sequence();
        test_valid_gaps();
        test_misplaced_sync();
        test_missing_sync();
        test_reset_midframe();
        test_back_to_back();
        test_random_model();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 2: consecutive correctly placed frame syncs needed to declare lock (range 1..7).
REQ-002 SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port din_valid, input, 1, din/fsync sampled this cycle.
REQ-005 SHALL have port din, input, 1, serial TDM data bit for the current slot.
REQ-006 SHALL have port fsync, input, 1, marks slot 0 of a 4-slot frame; ignored when din_valid=0.
REQ-007 SHALL have port dout, output, 4, last complete frame; dout[k] = bit received in slot k.
REQ-008 SHALL have port dout_valid, output, 1, one-cycle pulse when dout updates.
REQ-009 SHALL have port slot, output, 2, slot index the next accepted din_valid bit will occupy.
REQ-010 SHALL have port locked, output, 1, high in state LOCKED.
REQ-011 SHALL have port sync_err, output, 1, one-cycle pulse on a frame-sync violation while LOCKED.

Function
REQ-012 SHALL implement states HUNT, VERIFY, LOCKED; all state, counter and output updates on rising clk only when din_valid=1, except pulse clearing.
REQ-013 HUNT: din_valid&fsync -> store din as slot 0, slot<=1, good_cnt<=1, go VERIFY (or LOCKED directly if LOCK_CNT=1); other samples discarded, slot held at 0.
REQ-014 Slot counter SHALL increment by 1 per accepted bit, wrapping 3->0.
REQ-015 VERIFY: fsync=1 at slot 0 -> good_cnt+1; reaching LOCK_CNT -> LOCKED the same edge.
REQ-016 VERIFY: fsync=0 at slot 0 -> HUNT, slot<=0; fsync=1 at slot 1..3 -> treated as new slot 0: slot<=1, good_cnt<=1, stay VERIFY.
REQ-017 LOCKED: sample at slot 3 completes frame; dout SHALL load {slot3..slot0} and dout_valid SHALL pulse on that same edge (latency 1 cycle from slot-3 sample).
REQ-018 Frames SHALL be output only in LOCKED; frames completed in HUNT/VERIFY, including the one completing the lock-qualifying sync, SHALL NOT pulse dout_valid.
REQ-019 LOCKED, fsync=1 at slot 1..3: sync_err pulse, partial frame discarded, bit stored as slot 0, slot<=1, remain LOCKED.
REQ-020 LOCKED, fsync=0 at slot 0: sync_err pulse, locked drops, go HUNT, slot<=0, partial frame discarded.
REQ-021 dout SHALL hold its last value across loss of lock and resync; only REQ-017 changes it.
REQ-022 din_valid=0 cycles SHALL freeze slot, state and partial frame indefinitely.
REQ-023 dout_valid and sync_err SHALL never be high simultaneously; both SHALL be low on any cycle without an accepted bit.

Reset
REQ-024 rst_n low SHALL immediately force state HUNT, slot=0, good_cnt=0, partial frame=0, dout=4'b0000, dout_valid=0, locked=0, sync_err=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; first post-reset frame needs full lock qualification.
REQ-026 Reset deassertion SHALL be synchronised for release; first accepted sample is the first rising edge after release.

Structure
REQ-027 State enum (HUNT, VERIFY, LOCKED), NSLOT=4 and slot width 2 SHALL live in shared package tdm_pkg, reused by the matching tdm_mux4 transmitter.
REQ-028 Frame-sync tracker (state, good_cnt, slot) SHALL be sub-module tdm_sync_fsm; the data shift/capture path stays in tdm_demux4.
REQ-029 Design SHALL be fully synchronous apart from rst_n, gate-level synthesizable, no latches, compatible with $faultEnumerate/$generatePatterns flows.

Verification
REQ-030 Reset, then frames 1010,0110,1111 (slot0 first, fsync on slot 0), LOCK_CNT=2 -> locked after 2nd fsync; dout_valid only for frame 3, dout=4'b1111.
REQ-031 Locked, feed slot bits 1,0,1,1 with din_valid toggling 1/0 -> dout=4'b1101, single dout_valid pulse after 4th valid bit.
REQ-032 Locked, fsync asserted at slot 2 -> sync_err pulse, slot=1 next, locked stays 1, no dout_valid for the broken frame.
REQ-033 Locked, fsync missing at slot 0 -> sync_err pulse, locked=0, slot=0, dout unchanged.
REQ-034 rst_n pulsed low while slot=2 in LOCKED -> all outputs at REQ-024 values immediately, 2 valid fsync frames needed before next dout_valid.
REQ-035 Back-to-back bench: tdm_mux4 -> tdm_demux4 with 100 random 4-bit frames -> every dout after lock equals transmitted frame, zero sync_err.
